// File: rtl/issue_buffer_pkg.sv
// Shared pipeline constants for the issue buffer: write-class encodings,
// RV32I major opcodes, the NOP word and the per-entry decoded fields.
package issue_buffer_pkg;

  // Write class of an instruction as seen by the scoreboard
  typedef enum logic [1:0] {
    WT_IDLE = 2'd0,
    WT_ALU  = 2'd1,
    WT_LD   = 2'd2
  } wtype_e;

  // Occupancy of the two-entry buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0 -- presented while nothing is buffered
  localparam logic [31:0] NOP_INS = 32'h00000013;

  // Register-file view of one instruction, captured at push time
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    wtype_e     wtype;
  } dec_t;

endpackage

// File: rtl/issue_decode.sv
// Combinational RV32I decode: extracts source/destination indices and the
// write class. Sources an opcode does not read are reported as x0 so the
// scoreboard never stalls on a field that is really immediate bits.
module issue_decode
  import issue_buffer_pkg::*;
(
  input  logic [31:0] ins_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [1:0]  type_o
);

  logic [6:0] opcode;
  logic       use_rs1;
  logic       use_rs2;
  wtype_e     wtype;
  logic       unused_bits;

  assign opcode      = ins_i[6:0];
  assign unused_bits = ^{ins_i[31:25], ins_i[14:12]};

  // Opcode -> which sources are read and what kind of write is produced
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wtype   = WT_IDLE;
    case (opcode)
      OPC_LOAD:                   begin wtype = WT_LD;  use_rs1 = 1'b1; end
      OPC_OP_IMM, OPC_JALR:       begin wtype = WT_ALU; use_rs1 = 1'b1; end
      OPC_OP:                     begin wtype = WT_ALU; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL: wtype = WT_ALU;
      OPC_STORE, OPC_BRANCH:      begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:                    wtype = WT_IDLE;
    endcase
  end

  assign rs1_o  = use_rs1 ? ins_i[19:15] : 5'd0;
  assign rs2_o  = use_rs2 ? ins_i[24:20] : 5'd0;
  assign rd_o   = ins_i[11:7];
  // Writes to x0 are discarded, so they never need scoreboard tracking
  assign type_o = (ins_i[11:7] == 5'd0) ? WT_IDLE : wtype;

endmodule

// File: rtl/issue_buffer.sv
// Two-entry in-order issue buffer between fetch and execute. Entry 0 is
// always the head; entry 1 shifts into it when the head issues while full.
// Scoreboard-facing fields come only from registers, never from STALL_ENABLE.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  input  logic [31:0]         IN_INS,
  input  logic [PC_WIDTH-1:0] IN_PC,
  output logic                IN_READY,
  input  logic                STALL_ENABLE,
  input  logic                DATA_CACHE_READY,
  input  logic                INS_CACHE_READY,
  input  logic                FLUSH,
  output logic [4:0]          RS1_SEL,
  output logic [4:0]          RS2_SEL,
  output logic [4:0]          RD_OUT,
  output logic [1:0]          TYPE_OUT,
  output logic [31:0]         INS_OUT,
  output logic [PC_WIDTH-1:0] PC_OUT,
  output logic                ISSUE
);

  typedef struct packed {
    logic [31:0]         ins;
    logic [PC_WIDTH-1:0] pc;
    dec_t                dec;
  } entry_t;

  state_e     state_q, state_d;
  entry_t     ent_q [2];
  entry_t     ent_d [2];
  entry_t     new_ent;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic [1:0] dec_type;
  logic       non_empty;
  logic       push;

  issue_decode u_decode (
    .ins_i  (IN_INS),
    .rs1_o  (dec_rs1),
    .rs2_o  (dec_rs2),
    .rd_o   (dec_rd),
    .type_o (dec_type)
  );

  assign new_ent.ins       = IN_INS;
  assign new_ent.pc        = IN_PC;
  assign new_ent.dec.rs1   = dec_rs1;
  assign new_ent.dec.rs2   = dec_rs2;
  assign new_ent.dec.rd    = dec_rd;
  assign new_ent.dec.wtype = wtype_e'(dec_type);

  assign non_empty = (state_q != ST_EMPTY);
  assign ISSUE     = non_empty & STALL_ENABLE & DATA_CACHE_READY & INS_CACHE_READY & ~FLUSH;
  assign IN_READY  = (state_q != ST_TWO) | ISSUE;
  assign push      = IN_VALID & IN_READY & ~FLUSH;

  // Next occupancy and entry contents: shift on issue, then place the new
  // instruction in the first slot that is free after the shift
  always_comb begin
    state_d  = state_q;
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          ent_d[0] = new_ent;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && ISSUE) begin
          ent_d[0] = new_ent;
        end else if (push) begin
          ent_d[1] = new_ent;
          state_d  = ST_TWO;
        end else if (ISSUE) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (ISSUE) begin
          ent_d[0] = ent_q[1];
          if (push) ent_d[1] = new_ent;
          else      state_d  = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A redirect discards everything, including whatever arrived this cycle
    if (FLUSH) state_d = ST_EMPTY;
  end

  // State and entry registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_EMPTY;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

  assign RS1_SEL  = non_empty ? ent_q[0].dec.rs1 : 5'd0;
  assign RS2_SEL  = non_empty ? ent_q[0].dec.rs2 : 5'd0;
  assign RD_OUT   = non_empty ? ent_q[0].dec.rd  : 5'd0;
  assign INS_OUT  = non_empty ? ent_q[0].ins     : NOP_INS;
  assign PC_OUT   = non_empty ? ent_q[0].pc      : '0;
  // The write class only reaches the scoreboard when the head really leaves
  assign TYPE_OUT = ISSUE ? ent_q[0].dec.wtype : WT_IDLE;

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: hand-computed expectations for push,
// in-order issue, stall, cache back-pressure, flush and async reset.
module tb_issue_buffer;

  localparam int PC_WIDTH = 32;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADD1  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] LW5   = 32'h00022283; // lw   x5,0(x4)
  localparam logic [31:0] ADD6  = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] ADDI9 = 32'h00510493; // addi x9,x2,5
  localparam logic [31:0] SW7   = 32'h00742023; // sw   x7,0(x8)
  localparam logic [31:0] LUI0  = 32'h12345037; // lui  x0,0x12345

  logic                CLK;
  logic                RST_N;
  logic                IN_VALID;
  logic [31:0]         IN_INS;
  logic [PC_WIDTH-1:0] IN_PC;
  logic                IN_READY;
  logic                STALL_ENABLE;
  logic                DATA_CACHE_READY;
  logic                INS_CACHE_READY;
  logic                FLUSH;
  logic [4:0]          RS1_SEL;
  logic [4:0]          RS2_SEL;
  logic [4:0]          RD_OUT;
  logic [1:0]          TYPE_OUT;
  logic [31:0]         INS_OUT;
  logic [PC_WIDTH-1:0] PC_OUT;
  logic                ISSUE;

  int vec_cnt;
  int err_cnt;

  issue_buffer #(.PC_WIDTH(PC_WIDTH)) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .IN_VALID         (IN_VALID),
    .IN_INS           (IN_INS),
    .IN_PC            (IN_PC),
    .IN_READY         (IN_READY),
    .STALL_ENABLE     (STALL_ENABLE),
    .DATA_CACHE_READY (DATA_CACHE_READY),
    .INS_CACHE_READY  (INS_CACHE_READY),
    .FLUSH            (FLUSH),
    .RS1_SEL          (RS1_SEL),
    .RS2_SEL          (RS2_SEL),
    .RD_OUT           (RD_OUT),
    .TYPE_OUT         (TYPE_OUT),
    .INS_OUT          (INS_OUT),
    .PC_OUT           (PC_OUT),
    .ISSUE            (ISSUE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Advance past the next rising edge so inputs change away from it
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vec_cnt          = 0;
    err_cnt          = 0;
    RST_N            = 1'b0;
    IN_VALID         = 1'b0;
    IN_INS           = 32'h0;
    IN_PC            = '0;
    STALL_ENABLE     = 1'b0;
    DATA_CACHE_READY = 1'b0;
    INS_CACHE_READY  = 1'b0;
    FLUSH            = 1'b0;

    // Reset state
    #2;
    chk("rst_ins",   INS_OUT,  NOP);
    chk("rst_ready", IN_READY, 1);
    chk("rst_issue", ISSUE,    0);
    chk("rst_rs1",   RS1_SEL,  0);
    chk("rst_pc",    PC_OUT,   0);
    #10;

    // 1: ADD into EMPTY, issues the next cycle
    RST_N = 1'b1; IN_VALID = 1'b1; IN_INS = ADD1; IN_PC = 32'd100;
    STALL_ENABLE = 1'b1; DATA_CACHE_READY = 1'b1; INS_CACHE_READY = 1'b1;
    #1;
    chk("s1_ready_empty", IN_READY, 1);
    chk("s1_issue_empty", ISSUE,    0);
    tick;
    IN_VALID = 1'b0;
    #1;
    chk("s1_rs1",   RS1_SEL,  1);
    chk("s1_rs2",   RS2_SEL,  2);
    chk("s1_rd",    RD_OUT,   3);
    chk("s1_type",  TYPE_OUT, 1);
    chk("s1_issue", ISSUE,    1);
    chk("s1_pc",    PC_OUT,   100);
    tick;
    chk("s1_empty_issue", ISSUE,   0);
    chk("s1_empty_ins",   INS_OUT, NOP);

    // 2: LW then ADD with stall, fill to TWO, then drain in order
    STALL_ENABLE = 1'b0;
    IN_VALID = 1'b1; IN_INS = LW5; IN_PC = 32'd200;
    tick;
    IN_INS = ADD6; IN_PC = 32'd204;
    tick;
    IN_INS = ADDI9; IN_PC = 32'd208;
    #1;
    chk("s2_ready_full", IN_READY, 0);
    chk("s2_type_stall", TYPE_OUT, 0);
    chk("s2_issue_stall", ISSUE,   0);
    chk("s2_rs1",        RS1_SEL,  4);
    chk("s2_rd",         RD_OUT,   5);
    chk("s2_pc",         PC_OUT,   200);
    tick;
    chk("s2_pc_hold",    PC_OUT,   200);
    chk("s2_ready_hold", IN_READY, 0);
    IN_VALID = 1'b0; STALL_ENABLE = 1'b1;
    #1;
    chk("s2_issue_lw", ISSUE,    1);
    chk("s2_type_lw",  TYPE_OUT, 2);
    chk("s2_rd_lw",    RD_OUT,   5);
    tick;
    chk("s2_issue_add", ISSUE,    1);
    chk("s2_type_add",  TYPE_OUT, 1);
    chk("s2_rs1_add",   RS1_SEL,  5);
    chk("s2_rs2_add",   RS2_SEL,  5);
    chk("s2_rd_add",    RD_OUT,   6);
    chk("s2_pc_add",    PC_OUT,   204);
    tick;
    chk("s2_drained",   ISSUE,    0);
    chk("s2_nop",       INS_OUT,  NOP);

    // 3: FLUSH while TWO with a valid input
    STALL_ENABLE = 1'b0;
    IN_VALID = 1'b1; IN_INS = ADD1; IN_PC = 32'd300;
    tick;
    IN_PC = 32'd304;
    tick;
    IN_INS = LUI0; IN_PC = 32'd308; FLUSH = 1'b1; STALL_ENABLE = 1'b1;
    #1;
    chk("s3_issue_flush", ISSUE,    0);
    chk("s3_ready_flush", IN_READY, 0);
    tick;
    FLUSH = 1'b0; IN_VALID = 1'b0;
    #1;
    chk("s3_ins",   INS_OUT,  NOP);
    chk("s3_pc",    PC_OUT,   0);
    chk("s3_issue", ISSUE,    0);
    chk("s3_ready", IN_READY, 1);

    // 4: cache back-pressure while ONE, then store issue, LUI x0, ADDI
    DATA_CACHE_READY = 1'b0; INS_CACHE_READY = 1'b1;
    IN_VALID = 1'b1; IN_INS = SW7; IN_PC = 32'd400;
    tick;
    IN_VALID = 1'b0;
    #1;
    chk("s4_dcache_issue", ISSUE,   0);
    chk("s4_rs1",          RS1_SEL, 8);
    chk("s4_rs2",          RS2_SEL, 7);
    tick;
    DATA_CACHE_READY = 1'b1; INS_CACHE_READY = 1'b0;
    #1;
    chk("s4_icache_issue", ISSUE,   0);
    chk("s4_pc_stable",    PC_OUT,  400);
    tick;
    DATA_CACHE_READY = 1'b0;
    #1;
    chk("s4_both_issue", ISSUE,   0);
    chk("s4_ins_stable", INS_OUT, SW7);
    tick;
    DATA_CACHE_READY = 1'b1; INS_CACHE_READY = 1'b1;
    IN_VALID = 1'b1; IN_INS = LUI0; IN_PC = 32'd500;
    #1;
    chk("s4_sw_issue", ISSUE,    1);
    chk("s4_sw_type",  TYPE_OUT, 0);
    chk("s4_sw_rs1",   RS1_SEL,  8);
    chk("s4_sw_rs2",   RS2_SEL,  7);
    chk("s4_sw_ready", IN_READY, 1);
    tick;
    IN_INS = ADDI9; IN_PC = 32'd504;
    #1;
    chk("s4_lui_issue", ISSUE,    1);
    chk("s4_lui_type",  TYPE_OUT, 0);
    chk("s4_lui_ins",   INS_OUT,  LUI0);
    chk("s4_lui_rs1",   RS1_SEL,  0);
    chk("s4_lui_rs2",   RS2_SEL,  0);
    tick;
    IN_VALID = 1'b0;
    #1;
    chk("s4_addi_rs1",  RS1_SEL,  2);
    chk("s4_addi_rs2",  RS2_SEL,  0);
    chk("s4_addi_rd",   RD_OUT,   9);
    chk("s4_addi_type", TYPE_OUT, 1);
    tick;
    chk("s4_drained",   ISSUE,    0);

    // 5: asynchronous reset mid-cycle while TWO
    STALL_ENABLE = 1'b0;
    IN_VALID = 1'b1; IN_INS = ADD1; IN_PC = 32'd600;
    tick;
    IN_PC = 32'd604;
    tick;
    IN_VALID = 1'b0;
    #1;
    chk("s5_head_pc", PC_OUT, 600);
    #1;
    RST_N = 1'b0; STALL_ENABLE = 1'b1;
    #1;
    chk("s5_ins",   INS_OUT,  NOP);
    chk("s5_rs1",   RS1_SEL,  0);
    chk("s5_rs2",   RS2_SEL,  0);
    chk("s5_rd",    RD_OUT,   0);
    chk("s5_pc",    PC_OUT,   0);
    chk("s5_ready", IN_READY, 1);
    chk("s5_issue", ISSUE,    0);
    chk("s5_type",  TYPE_OUT, 0);
    #1;
    RST_N = 1'b1;
    tick;
    chk("s5_post_ins",   INS_OUT, NOP);
    chk("s5_post_issue", ISSUE,   0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 SHALL have parameter: PC_WIDTH  32  width of PC field carried with each instruction.
REQ-002 SHALL have ports, in order:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  upstream holds a fetched instruction.
- IN_INS  in  32  RV32I instruction word.
- IN_PC  in  PC_WIDTH  instruction address.
- IN_READY  out  1  buffer accepts IN_* this cycle.
- STALL_ENABLE  in  1  1 = head operands available from the scoreboard.
- DATA_CACHE_READY  in  1  data cache not busy.
- INS_CACHE_READY  in  1  instruction cache not busy.
- FLUSH  in  1  branch/jump redirect; discard all buffered instructions.
- RS1_SEL  out  5  head rs1 index to the scoreboard (0 if unused).
- RS2_SEL  out  5  head rs2 index to the scoreboard (0 if unused).
- RD_OUT  out  5  head destination index.
- TYPE_OUT  out  2  head write class {idle, alu, ld}, gated by issue.
- INS_OUT  out  32  head instruction word.
- PC_OUT  out  PC_WIDTH  head PC.
- ISSUE  out  1  head leaves the buffer to execute this cycle.

Function
REQ-003 SHALL be a 2-entry in-order FIFO with states EMPTY, ONE, TWO; the head is the oldest entry.
REQ-004 SHALL set IN_READY = (state != TWO) | ISSUE; push = IN_VALID & IN_READY & !FLUSH.
REQ-005 SHALL set ISSUE = (state != EMPTY) & STALL_ENABLE & DATA_CACHE_READY & INS_CACHE_READY & !FLUSH.
REQ-006 Transitions: EMPTY->ONE on push; ONE->TWO on push & !ISSUE; ONE->EMPTY on ISSUE & !push; TWO->ONE on ISSUE; push & ISSUE together leaves the count unchanged.
REQ-007 SHALL force the state to EMPTY on the edge after any FLUSH cycle, regardless of push or ISSUE in that cycle.
REQ-008 SHALL decode at push time and store rs1, rs2, rd and type with the entry; RS*/RD/TYPE SHALL come from registered fields only.
REQ-009 Decode by opcode:
- LOAD 0000011: ld, uses rs1.
- OP-IMM 0010011, JALR 1100111: alu, uses rs1.
- OP 0110011: alu, uses rs1 and rs2.
- LUI 0110111, AUIPC 0010111, JAL 1101111: alu, no sources.
- STORE 0100011, BRANCH 1100011: idle, uses rs1 and rs2.
- Any other opcode: idle, no sources.
- An unused source SHALL be stored as index 0.
REQ-010 SHALL store type idle when rd = 0.
REQ-011 When EMPTY, SHALL drive RS1_SEL = RS2_SEL = RD_OUT = 0, TYPE_OUT = idle, INS_OUT = 32'h00000013, PC_OUT = 0.
REQ-012 SHALL drive TYPE_OUT = the head type only when ISSUE = 1, and idle otherwise.
REQ-013 SHALL drive RS*_SEL, RD_OUT, INS_OUT and PC_OUT from the head whenever it is non-empty, independent of ISSUE.
REQ-014 Latency: an instruction pushed at edge N is presented at the head from cycle N+1 if the buffer was EMPTY; the earliest ISSUE is cycle N+1.
REQ-015 There SHALL be no combinational path from STALL_ENABLE to RS1_SEL or RS2_SEL.

Reset
REQ-016 SHALL, while RST_N = 0, asynchronously force state EMPTY, both entries invalid, and outputs as in REQ-011, with IN_READY = 1 and ISSUE = 0.
REQ-017 Deassertion SHALL be sampled synchronously; the first push is allowed on the first edge with RST_N = 1.

Structure
REQ-018 The type encodings (idle, alu, ld), the RV32I opcode constants and the NOP word SHALL live in the shared pipeline parameter include.
REQ-019 The opcode decode SHALL be one combinational sub-module, issue_decode (IN_INS -> rs1, rs2, rd, type).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Push ADD x3,x1,x2 (32'h002081B3) into EMPTY with STALL_ENABLE = 1 -> next cycle RS1_SEL = 1, RS2_SEL = 2, RD_OUT = 3, TYPE_OUT = alu, ISSUE = 1.
- Push LW x5,0(x4) then ADD x6,x5,x5 with STALL_ENABLE = 0 for 2 cycles -> state TWO, IN_READY = 0, TYPE_OUT = idle; then STALL_ENABLE = 1 -> issues in order, one per cycle.
- FLUSH = 1 while in TWO with IN_VALID = 1 -> next cycle EMPTY, INS_OUT = 32'h00000013, and the input is not captured.
- DATA_CACHE_READY = 0 or INS_CACHE_READY = 0 for 3 cycles while in ONE -> ISSUE = 0 and head fields stable; ISSUE = 1 the cycle both are ready.
- Store SW x7,0(x8) -> RS1_SEL = 8, RS2_SEL = 7, TYPE_OUT = idle on issue; LUI x0 -> TYPE_OUT = idle.
- RST_N = 0 mid-cycle while in TWO -> outputs reach REQ-011 values immediately, without waiting for a CLK edge.
